// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, master index
// and one-hot grant encodings.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT0,
        ARB_GNT1
    } arb_state_t;

    typedef logic mst_idx_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_bus_timeout.sv
// Bus watchdog: counts stalled strobe cycles and emits a registered one-cycle
// pulse once the count reaches TIMEOUT. TIMEOUT=0 ties the watchdog off.
module wb_bus_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic fire_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused = ^{clk_i, rst_i, clr_i, run_i};
            assign fire_o   = 1'b0;
        end else begin : g_on
            localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_cnt;
            logic          r_fire;

            // The pulse is registered from the increment that reaches TIMEOUT,
            // and both counter and pulse clear in the cycle the pulse is out.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_cnt  <= '0;
                    r_fire <= 1'b0;
                end else if (clr_i || r_fire) begin
                    r_cnt  <= '0;
                    r_fire <= 1'b0;
                end else if (run_i) begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_fire <= (r_cnt == LAST);
                end
            end

            assign fire_o = r_fire;
        end
    endgenerate

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter (CPU bridge = m0, DMA = m1) onto a single system
// bus port; grants are held for the whole CYC, hung slaves are cut off by a watchdog.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PRIORITY   = 0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    input  logic                  m0_we_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    input  logic                  m1_we_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    output logic                  s_we_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,

    output logic [1:0]            gnt_o,
    output logic                  timeout_o
);

    arb_state_t r_state;
    arb_state_t w_next;
    mst_idx_t   r_last_gnt;
    logic       w_fire;
    logic       w_clr;
    logic       w_stb_raw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == ARB_GNT0 && !m0_cyc_i) begin
                r_last_gnt <= 1'b0;
            end else if (r_state == ARB_GNT1 && !m1_cyc_i) begin
                r_last_gnt <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next = (PRIORITY != 0 || r_last_gnt == 1'b1) ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_cyc_i) begin
                    w_next = ARB_GNT0;
                end else if (m1_cyc_i) begin
                    w_next = ARB_GNT1;
                end
            end
            ARB_GNT0: if (!m0_cyc_i) w_next = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
            ARB_GNT1: if (!m1_cyc_i) w_next = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
            default:  w_next = ARB_IDLE;
        endcase
    end

    // ERR beats ACK, and a watchdog pulse suppresses both the slave ACK and the strobe.
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        w_stb_raw = 1'b0;
        gnt_o     = GNT_NONE;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        case (r_state)
            ARB_GNT0: begin
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
                s_we_o    = m0_we_i;
                s_cyc_o   = m0_cyc_i;
                w_stb_raw = m0_stb_i;
                gnt_o     = GNT_M0;
                m0_ack_o  = m0_cyc_i & s_ack_i & ~s_err_i & ~w_fire;
                m0_err_o  = w_fire | (m0_cyc_i & s_err_i);
            end
            ARB_GNT1: begin
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
                s_we_o    = m1_we_i;
                s_cyc_o   = m1_cyc_i;
                w_stb_raw = m1_stb_i;
                gnt_o     = GNT_M1;
                m1_ack_o  = m1_cyc_i & s_ack_i & ~s_err_i & ~w_fire;
                m1_err_o  = w_fire | (m1_cyc_i & s_err_i);
            end
            default: ;
        endcase
        s_stb_o = w_stb_raw & ~w_fire;
    end

    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign timeout_o = w_fire;

    // Clearing on a pending state change keeps a pulse from landing on the next owner.
    assign w_clr = (w_next != r_state) | s_ack_i | s_err_i | ~s_stb_o;

    wb_bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_clr),
        .run_i  (s_stb_o),
        .fire_o (w_fire)
    );

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench: uA is round-robin with an 8-cycle watchdog, uB is CPU-priority
// with the watchdog disabled; both share the master and slave stimulus.
module tb_wb_bus_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    // {gnt[1:0], s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, timeout}
    typedef logic [8:0] obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] m0_adr = '0, m1_adr = '0;
    logic [DW-1:0] m0_dat_w = '0, m1_dat_w = '0, s_dat_rd = '0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic          m0_cyc = 1'b0, m0_stb = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
    logic          s_ack = 1'b0, s_err = 1'b0;

    logic [DW-1:0] a_m0_dat, a_m1_dat, a_s_dat, b_m0_dat, b_m1_dat, b_s_dat;
    logic [AW-1:0] a_s_adr, b_s_adr;
    logic          a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_we, a_s_stb, a_s_cyc, a_to;
    logic          b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_we, b_s_stb, b_s_cyc, b_to;
    logic [1:0]    a_gnt, b_gnt;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    obs_t        exp_q[$];
    logic [5:0]  stim_q[$];

    always #5 clk = ~clk;

    wb_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIORITY(0), .TIMEOUT(8)
    ) uA (
        .clk_i(clk), .rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_w), .m0_dat_o(a_m0_dat), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_w), .m1_dat_o(a_m1_dat), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_dat_i(s_dat_rd), .s_we_o(a_s_we),
        .s_stb_o(a_s_stb), .s_cyc_o(a_s_cyc), .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(a_gnt), .timeout_o(a_to)
    );

    wb_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIORITY(1), .TIMEOUT(0)
    ) uB (
        .clk_i(clk), .rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_w), .m0_dat_o(b_m0_dat), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_w), .m1_dat_o(b_m1_dat), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_dat_i(s_dat_rd), .s_we_o(b_s_we),
        .s_stb_o(b_s_stb), .s_cyc_o(b_s_cyc), .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(b_gnt), .timeout_o(b_to)
    );

    function automatic obs_t obs_a();
        return {a_gnt, a_s_cyc, a_s_stb, a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_to};
    endfunction

    function automatic obs_t obs_b();
        return {b_gnt, b_s_cyc, b_s_stb, b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_to};
    endfunction

    // Stimulus word: {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err}; applied at negedge,
    // outputs observed 1 time unit later.
    task automatic drive(input logic [5:0] v);
        @(negedge clk);
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = v;
        #1;
    endtask

    task automatic do_reset();
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [5:0] s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        obs_t got;
        rst      = 1'b1;
        s_dat_rd = 16'hBEEF;
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = 6'b11_11_10;
        @(negedge clk);
        #1;
        got = obs_a();
        n_chk++;
        if (got !== 9'b0) $display("FAIL reset_obs_a: got %b want %b", got, 9'b0);
        else n_pass++;
        got = obs_b();
        n_chk++;
        if (got !== 9'b0) $display("FAIL reset_obs_b: got %b want %b", got, 9'b0);
        else n_pass++;
        n_chk++;
        if (a_m0_dat !== 16'hBEEF || a_m1_dat !== 16'hBEEF || a_s_adr !== '0)
            $display("FAIL reset_data: got m0_dat=%h m1_dat=%h s_adr=%h want BEEF BEEF 0",
                     a_m0_dat, a_m1_dat, a_s_adr);
        else n_pass++;
    endtask

    task automatic test_cpu_read();
        obs_t e, got;
        do_reset();
        m0_adr = 24'h100002; m0_dat_w = 16'hA5A5; m0_we = 1'b0; s_dat_rd = 16'h1234;
        push(6'b11_00_00, 9'b00_0_0_0000_0);
        push(6'b11_00_00, 9'b01_1_1_0000_0);
        push(6'b11_00_00, 9'b01_1_1_0000_0);
        push(6'b11_00_10, 9'b01_1_1_1000_0);
        push(6'b00_00_00, 9'b01_0_0_0000_0);
        push(6'b00_00_00, 9'b00_0_0_0000_0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            got = obs_a();
            n_chk++;
            if (got !== e) $display("FAIL cpu_read c%0d: got %b want %b", i, got, e);
            else n_pass++;
            if (i == 1) begin
                n_chk++;
                if (a_s_adr !== 24'h100002 || a_s_dat !== 16'hA5A5 || a_s_we !== 1'b0)
                    $display("FAIL cpu_read_mux: got adr=%h dat=%h we=%b want 100002 A5A5 0",
                             a_s_adr, a_s_dat, a_s_we);
                else n_pass++;
            end
            if (i == 3) begin
                n_chk++;
                if (a_m0_dat !== 16'h1234) $display("FAIL cpu_read_data: got %h want 1234", a_m0_dat);
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        obs_t e, got;
        do_reset();
        push(6'b11_11_00, 9'b00_0_0_0000_0);
        push(6'b11_11_00, 9'b01_1_1_0000_0);
        push(6'b11_11_10, 9'b01_1_1_1000_0);
        push(6'b00_11_00, 9'b01_0_0_0000_0);
        push(6'b00_11_00, 9'b10_1_1_0000_0);
        push(6'b00_11_10, 9'b10_1_1_0010_0);
        push(6'b00_00_00, 9'b10_0_0_0000_0);
        push(6'b11_11_00, 9'b00_0_0_0000_0);
        push(6'b11_11_00, 9'b01_1_1_0000_0);
        push(6'b00_00_00, 9'b01_0_0_0000_0);
        push(6'b00_00_00, 9'b00_0_0_0000_0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            got = obs_a();
            n_chk++;
            if (got !== e) $display("FAIL round_robin c%0d: got %b want %b", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_priority_block();
        obs_t e, got;
        do_reset();
        m1_adr = 24'h2000A0;
        push(6'b00_11_00, 9'b00_0_0_0000_0);
        for (int w = 1; w <= 16; w++)
            push({(w >= 3) ? 2'b11 : 2'b00, 4'b11_10}, 9'b10_1_1_0010_0);
        push(6'b11_00_00, 9'b10_0_0_0000_0);
        push(6'b11_00_00, 9'b01_1_1_0000_0);
        push(6'b11_00_10, 9'b01_1_1_1000_0);
        push(6'b00_00_00, 9'b01_0_0_0000_0);
        push(6'b00_00_00, 9'b00_0_0_0000_0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            got = obs_b();
            n_chk++;
            if (got !== e) $display("FAIL priority_block c%0d: got %b want %b", i, got, e);
            else n_pass++;
            if (i == 1) begin
                n_chk++;
                if (b_s_adr !== 24'h2000A0) $display("FAIL priority_adr: got %h want 2000A0", b_s_adr);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        obs_t e, got;
        do_reset();
        push(6'b00_11_00, 9'b00_0_0_0000_0);
        for (int k = 1; k <= 8; k++) push(6'b00_11_00, 9'b10_1_1_0000_0);
        push(6'b00_11_10, 9'b10_1_0_0001_1);
        push(6'b00_11_00, 9'b10_1_1_0000_0);
        push(6'b00_00_00, 9'b10_0_0_0000_0);
        push(6'b00_00_00, 9'b00_0_0_0000_0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            got = obs_a();
            n_chk++;
            if (got !== e) $display("FAIL timeout c%0d: got %b want %b", i, got, e);
            else n_pass++;
            if (i == 9) begin
                got = obs_b();
                n_chk++;
                if (got !== 9'b10_1_1_0010_0)
                    $display("FAIL timeout_disabled: got %b want %b", got, 9'b10_1_1_0010_0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ack_err();
        obs_t e, got;
        do_reset();
        push(6'b11_00_00, 9'b00_0_0_0000_0);
        push(6'b11_00_11, 9'b01_1_1_0100_0);
        push(6'b00_00_10, 9'b01_0_0_0000_0);
        push(6'b00_00_10, 9'b00_0_0_0000_0);
        push(6'b00_00_01, 9'b00_0_0_0000_0);
        push(6'b00_00_00, 9'b00_0_0_0000_0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            got = obs_a();
            n_chk++;
            if (got !== e) $display("FAIL ack_err c%0d: got %b want %b", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_dma();
        obs_t e, got;
        do_reset();
        push(6'b00_11_00, 9'b00_0_0_0000_0);
        push(6'b00_11_00, 9'b10_1_1_0000_0);
        push(6'b11_11_00, 9'b10_1_1_0000_0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            got = obs_a();
            n_chk++;
            if (got !== e) $display("FAIL reset_mid pre c%0d: got %b want %b", i, got, e);
            else n_pass++;
        end
        #1 rst = 1'b1;
        #1;
        got = obs_a();
        n_chk++;
        if (got !== 9'b0 || a_s_adr !== '0)
            $display("FAIL reset_mid_async: got %b adr=%h want %b adr=0", got, a_s_adr, 9'b0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        got = obs_a();
        n_chk++;
        if (got !== 9'b0) $display("FAIL reset_mid_idle: got %b want %b", got, 9'b0);
        else n_pass++;
        push(6'b11_11_00, 9'b01_1_1_0000_0);
        push(6'b00_11_00, 9'b01_0_0_0000_0);
        push(6'b00_11_00, 9'b10_1_1_0000_0);
        push(6'b00_00_00, 9'b10_0_0_0000_0);
        push(6'b00_00_00, 9'b00_0_0_0000_0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            got = obs_a();
            n_chk++;
            if (got !== e) $display("FAIL reset_mid post c%0d: got %b want %b", i, got, e);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got no finish want finish before 200000");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_priority_block();
        test_timeout();
        test_ack_err();
        test_reset_mid_dma();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
